// File: rtl/pipe_hazard_ctrl_if.sv
// -----------------------------------------------------------------------------
// pipe_hazard_ctrl_if
// Groups the hazard-detection inputs and the pipeline control outputs of
// pipe_hazard_ctrl into one bundle.
//   master : pipeline side. It drives decode/execute/memory status and
//            receives the stall, flush, bubble and status outputs.
//   slave  : hazard controller side. It is the mirror of master.
// Signals:
//   id_rs1/id_rs2, id_uses_rs1/id_uses_rs2 : decode source registers and
//                                            whether each field is read
//   ex_rd, ex_is_load, ex_branch_taken     : execute-stage status
//   mem_req, mem_ready                     : data-memory handshake
//   fetch_stall, decode_stall, ex_stall    : pipeline register holds
//   decode_flush, ex_bubble                : squash controls
//   mem_wait, mem_err                      : memory-wait status and abort pulse
//   stall_count, flush_count               : performance counters
// -----------------------------------------------------------------------------
interface pipe_hazard_ctrl_if #(
   parameter int REG_AW = 3
);
   logic [REG_AW-1:0] id_rs1;
   logic [REG_AW-1:0] id_rs2;
   logic              id_uses_rs1;
   logic              id_uses_rs2;
   logic [REG_AW-1:0] ex_rd;
   logic              ex_is_load;
   logic              ex_branch_taken;
   logic              mem_req;
   logic              mem_ready;
   logic              fetch_stall;
   logic              decode_stall;
   logic              ex_stall;
   logic              decode_flush;
   logic              ex_bubble;
   logic              mem_wait;
   logic              mem_err;
   logic [15:0]       stall_count;
   logic [15:0]       flush_count;

   modport master (
      output id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, ex_rd, ex_is_load,
             ex_branch_taken, mem_req, mem_ready,
      input  fetch_stall, decode_stall, ex_stall, decode_flush, ex_bubble,
             mem_wait, mem_err, stall_count, flush_count
   );

   modport slave (
      input  id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, ex_rd, ex_is_load,
             ex_branch_taken, mem_req, mem_ready,
      output fetch_stall, decode_stall, ex_stall, decode_flush, ex_bubble,
             mem_wait, mem_err, stall_count, flush_count
   );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_hazard_ctrl
// Pipeline sequencing controller for the 16-bit core. It generates the stall,
// flush and bubble controls for the fetch/decode/execute registers. It covers
// load-use hazards, taken branches, and multi-cycle data-memory waits with a
// timeout abort.
// Priority, highest first: memory wait, branch flush, load-use.
// Ports:
//   clk  : core clock
//   rst  : asynchronous active-high reset; it also forces the controls low
//   bus  : pipe_hazard_ctrl_if.slave (hazard inputs and control outputs)
// Parameters:
//   REG_AW      : register-specifier width
//   MEM_TIMEOUT : MEM_WAIT cycles tolerated before abort (1..255)
// Configuration:
//   PIPE_HAZARD_PERF_EN : when defined, stall_count and flush_count are built
//                         as saturating 16-bit counters. Otherwise both
//                         outputs are tied to zero.
// -----------------------------------------------------------------------------
module pipe_hazard_ctrl #(
   parameter int REG_AW      = 3,
   parameter int MEM_TIMEOUT = 15
) (
   input logic              clk,
   input logic              rst,
   pipe_hazard_ctrl_if.slave bus
);
   typedef enum logic [0:0] {
      ST_RUN      = 1'b0,
      ST_MEM_WAIT = 1'b1
   } state_e;

   localparam logic [7:0] TIMEOUT_CNT = 8'(MEM_TIMEOUT);

   state_e            state_q, state_d;
   logic [7:0]        wait_cnt_q, wait_cnt_d;
   logic              mem_err_q, mem_err_d;

   logic [REG_AW-1:0] rs1_s, rs2_s, rd_s;
   logic              load_use_s;
   logic              mem_start_s;
   logic              fetch_stall_s, decode_stall_s, ex_stall_s;
   logic              decode_flush_s, ex_bubble_s, mem_wait_s;

   assign rs1_s = bus.id_rs1;
   assign rs2_s = bus.id_rs2;
   assign rd_s  = bus.ex_rd;

   assign load_use_s  = bus.ex_is_load &
                        ((bus.id_uses_rs1 & (rs1_s == rd_s)) |
                         (bus.id_uses_rs2 & (rs2_s == rd_s)));
   assign mem_start_s = bus.mem_req & ~bus.mem_ready;

   // State register, wait counter and timeout pulse
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= ST_RUN;
         wait_cnt_q <= 8'd0;
         mem_err_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         wait_cnt_q <= wait_cnt_d;
         mem_err_q  <= mem_err_d;
      end
   end

   // Next-state logic: enter MEM_WAIT on an unfinished access and leave it
   // on completion or timeout
   always_comb begin
      state_d    = state_q;
      wait_cnt_d = wait_cnt_q;
      mem_err_d  = 1'b0;
      case (state_q)
         ST_RUN: begin
            if (mem_start_s) begin
               state_d    = ST_MEM_WAIT;
               wait_cnt_d = 8'd1;
            end else begin
               wait_cnt_d = 8'd0;
            end
         end
         ST_MEM_WAIT: begin
            if (bus.mem_ready) begin
               // A completion in the timeout cycle still counts as success.
               state_d    = ST_RUN;
               wait_cnt_d = 8'd0;
            end else if (wait_cnt_q >= TIMEOUT_CNT) begin
               state_d    = ST_RUN;
               wait_cnt_d = 8'd0;
               mem_err_d  = 1'b1;
            end else begin
               wait_cnt_d = (wait_cnt_q == 8'hFF) ? 8'hFF : wait_cnt_q + 8'd1;
            end
         end
         default: begin
            state_d    = ST_RUN;
            wait_cnt_d = 8'd0;
         end
      endcase
   end

   // Output logic: zero-latency controls from the current state and inputs
   always_comb begin
      fetch_stall_s  = 1'b0;
      decode_stall_s = 1'b0;
      ex_stall_s     = 1'b0;
      decode_flush_s = 1'b0;
      ex_bubble_s    = 1'b0;
      mem_wait_s     = 1'b0;
      if (rst) begin
         // The controls drop as soon as reset asserts, even mid-wait.
         fetch_stall_s = 1'b0;
      end else begin
         case (state_q)
            ST_RUN: begin
               if (mem_start_s) begin
                  fetch_stall_s  = 1'b1;
                  decode_stall_s = 1'b1;
                  ex_stall_s     = 1'b1;
               end else if (bus.ex_branch_taken) begin
                  // The dependent instruction is discarded, so no load-use stall.
                  decode_flush_s = 1'b1;
                  ex_bubble_s    = 1'b1;
               end else if (load_use_s) begin
                  fetch_stall_s  = 1'b1;
                  decode_stall_s = 1'b1;
                  ex_bubble_s    = 1'b1;
               end else begin
                  ex_bubble_s = 1'b0;
               end
            end
            ST_MEM_WAIT: begin
               // Execute is frozen, so branch/load-use are re-evaluated after
               // release. The timeout cycle itself is still a stalled cycle.
               if (bus.mem_ready) begin
                  mem_wait_s = 1'b0;
               end else begin
                  fetch_stall_s  = 1'b1;
                  decode_stall_s = 1'b1;
                  ex_stall_s     = 1'b1;
                  mem_wait_s     = 1'b1;
               end
            end
            default: begin
               mem_wait_s = 1'b0;
            end
         endcase
      end
   end

   assign bus.fetch_stall  = fetch_stall_s;
   assign bus.decode_stall = decode_stall_s;
   assign bus.ex_stall     = ex_stall_s;
   assign bus.decode_flush = decode_flush_s;
   assign bus.ex_bubble    = ex_bubble_s;
   assign bus.mem_wait     = mem_wait_s;
   assign bus.mem_err      = mem_err_q;

`ifdef PIPE_HAZARD_PERF_EN
   logic [15:0] stall_cnt_q, stall_cnt_d;
   logic [15:0] flush_cnt_q, flush_cnt_d;

   // Saturating performance counter increments
   always_comb begin
      stall_cnt_d = stall_cnt_q;
      flush_cnt_d = flush_cnt_q;
      if (fetch_stall_s && (stall_cnt_q != 16'hFFFF)) begin
         stall_cnt_d = stall_cnt_q + 16'd1;
      end else begin
         stall_cnt_d = stall_cnt_q;
      end
      if (decode_flush_s && (flush_cnt_q != 16'hFFFF)) begin
         flush_cnt_d = flush_cnt_q + 16'd1;
      end else begin
         flush_cnt_d = flush_cnt_q;
      end
   end

   // Performance counter registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_cnt_q <= 16'd0;
         flush_cnt_q <= 16'd0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   assign bus.stall_count = stall_cnt_q;
   assign bus.flush_count = flush_cnt_q;
`else
   assign bus.stall_count = 16'd0;
   assign bus.flush_count = 16'd0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipe_hazard_ctrl
// Directed, self-checking bench for pipe_hazard_ctrl (MEM_TIMEOUT = 15).
// Inputs change 1 ns after a rising edge. Outputs are sampled on the falling
// edge. The counter expectations follow PIPE_HAZARD_PERF_EN.
// -----------------------------------------------------------------------------
module tb_pipe_hazard_ctrl;
   logic clk;
   logic rst;
   int   n_pass;
   int   n_total;
   int   exp_stall;
   int   exp_flush;

`ifdef PIPE_HAZARD_PERF_EN
   localparam bit PERF = 1'b1;
`else
   localparam bit PERF = 1'b0;
`endif

   pipe_hazard_ctrl_if #(.REG_AW(3)) bus_if ();

   pipe_hazard_ctrl #(.REG_AW(3), .MEM_TIMEOUT(15)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus_if)
   );

   // {fetch_stall, decode_stall, ex_stall, decode_flush, ex_bubble, mem_wait, mem_err}
   logic [6:0] ctl;
   assign ctl = {bus_if.fetch_stall, bus_if.decode_stall, bus_if.ex_stall,
                 bus_if.decode_flush, bus_if.ex_bubble, bus_if.mem_wait, bus_if.mem_err};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic drive_idle();
      bus_if.id_rs1          = 3'd0;
      bus_if.id_rs2          = 3'd0;
      bus_if.id_uses_rs1     = 1'b0;
      bus_if.id_uses_rs2     = 1'b0;
      bus_if.ex_rd           = 3'd0;
      bus_if.ex_is_load      = 1'b0;
      bus_if.ex_branch_taken = 1'b0;
      bus_if.mem_req         = 1'b0;
      bus_if.mem_ready       = 1'b0;
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      logic [15:0] es, ef;
      rst = 1'b1;
      bus_if.id_rs1          = 3'($urandom);
      bus_if.id_rs2          = 3'($urandom);
      bus_if.id_uses_rs1     = 1'($urandom);
      bus_if.id_uses_rs2     = 1'($urandom);
      bus_if.ex_rd           = 3'($urandom);
      bus_if.ex_is_load      = 1'($urandom);
      bus_if.ex_branch_taken = 1'($urandom);
      bus_if.mem_req         = 1'b1;
      bus_if.mem_ready       = 1'b0;
      next_cycle();
      next_cycle();
      @(negedge clk);
      n_total++; if (ctl !== 7'b0000000) $display("FAIL reset_ctl: got %b want %b", ctl, 7'b0000000); else n_pass++;
      n_total++; if (bus_if.stall_count !== 16'd0) $display("FAIL reset_stall_count: got %0d want 0", bus_if.stall_count); else n_pass++;
      n_total++; if (bus_if.flush_count !== 16'd0) $display("FAIL reset_flush_count: got %0d want 0", bus_if.flush_count); else n_pass++;
      drive_idle();
      next_cycle();
      rst = 1'b0;
      @(negedge clk);
      n_total++; if (ctl !== 7'b0000000) $display("FAIL post_reset_ctl: got %b want %b", ctl, 7'b0000000); else n_pass++;
      next_cycle();
      @(negedge clk);
      es = 16'(PERF ? exp_stall : 0);
      ef = 16'(PERF ? exp_flush : 0);
      n_total++; if (bus_if.stall_count !== es) $display("FAIL idle_stall_count: got %0d want %0d", bus_if.stall_count, es); else n_pass++;
      n_total++; if (bus_if.flush_count !== ef) $display("FAIL idle_flush_count: got %0d want %0d", bus_if.flush_count, ef); else n_pass++;
      next_cycle();
   endtask

   task automatic test_branch_vs_load_use();
      logic [15:0] es, ef;
      bus_if.ex_is_load = 1'b1; bus_if.ex_rd = 3'd3; bus_if.id_rs2 = 3'd3; bus_if.id_uses_rs2 = 1'b1;
      bus_if.ex_branch_taken = 1'b1;
      @(negedge clk);
      n_total++; if (ctl !== 7'b0001100) $display("FAIL branch_wins: got %b want %b", ctl, 7'b0001100); else n_pass++;
      exp_flush++;
      next_cycle();
      drive_idle();
      @(negedge clk);
      n_total++; if (ctl !== 7'b0000000) $display("FAIL branch_after_ctl: got %b want %b", ctl, 7'b0000000); else n_pass++;
      es = 16'(PERF ? exp_stall : 0);
      ef = 16'(PERF ? exp_flush : 0);
      n_total++; if (bus_if.flush_count !== ef) $display("FAIL branch_flush_count: got %0d want %0d", bus_if.flush_count, ef); else n_pass++;
      n_total++; if (bus_if.stall_count !== es) $display("FAIL branch_stall_count: got %0d want %0d", bus_if.stall_count, es); else n_pass++;
      next_cycle();
   endtask

   task automatic test_load_use();
      logic [15:0] es;
      // rs2 match
      bus_if.ex_is_load = 1'b1; bus_if.ex_rd = 3'd3; bus_if.id_rs2 = 3'd3; bus_if.id_uses_rs2 = 1'b1;
      bus_if.id_rs1 = 3'd5; bus_if.id_uses_rs1 = 1'b1;
      @(negedge clk);
      n_total++; if (ctl !== 7'b1100100) $display("FAIL lu_rs2: got %b want %b", ctl, 7'b1100100); else n_pass++;
      exp_stall++;
      next_cycle();
      // rs2 field not read
      bus_if.id_uses_rs2 = 1'b0;
      @(negedge clk);
      n_total++; if (ctl !== 7'b0000000) $display("FAIL lu_unused_rs2: got %b want %b", ctl, 7'b0000000); else n_pass++;
      next_cycle();
      // rs1 match
      bus_if.id_rs1 = 3'd3;
      @(negedge clk);
      n_total++; if (ctl !== 7'b1100100) $display("FAIL lu_rs1: got %b want %b", ctl, 7'b1100100); else n_pass++;
      exp_stall++;
      next_cycle();
      // matching register, but not a load
      bus_if.ex_is_load = 1'b0;
      @(negedge clk);
      n_total++; if (ctl !== 7'b0000000) $display("FAIL lu_not_load: got %b want %b", ctl, 7'b0000000); else n_pass++;
      next_cycle();
      // load, register mismatch
      bus_if.ex_is_load = 1'b1; bus_if.ex_rd = 3'd7;
      @(negedge clk);
      n_total++; if (ctl !== 7'b0000000) $display("FAIL lu_mismatch: got %b want %b", ctl, 7'b0000000); else n_pass++;
      next_cycle();
      drive_idle();
      @(negedge clk);
      es = 16'(PERF ? exp_stall : 0);
      n_total++; if (bus_if.stall_count !== es) $display("FAIL lu_stall_count: got %0d want %0d", bus_if.stall_count, es); else n_pass++;
      next_cycle();
   endtask

   task automatic test_mem_wait();
      logic [15:0] es;
      logic [6:0]  exp;
      bus_if.mem_req = 1'b1; bus_if.mem_ready = 1'b0;
      for (int c = 0; c < 4; c++) begin
         exp = (c == 0) ? 7'b1110000 : 7'b1110010;
         @(negedge clk);
         n_total++; if (ctl !== exp) $display("FAIL mw_wait_c%0d: got %b want %b", c, ctl, exp); else n_pass++;
         exp_stall++;
         next_cycle();
      end
      bus_if.mem_ready = 1'b1;
      @(negedge clk);
      n_total++; if (ctl !== 7'b0000000) $display("FAIL mw_release: got %b want %b", ctl, 7'b0000000); else n_pass++;
      next_cycle();
      // back-to-back request straight after release
      bus_if.mem_ready = 1'b0;
      @(negedge clk);
      es = 16'(PERF ? exp_stall : 0);
      n_total++; if (bus_if.stall_count !== es) $display("FAIL mw_stall_count: got %0d want %0d", bus_if.stall_count, es); else n_pass++;
      n_total++; if (ctl !== 7'b1110000) $display("FAIL b2b_reenter: got %b want %b", ctl, 7'b1110000); else n_pass++;
      exp_stall++;
      next_cycle();
      bus_if.mem_ready = 1'b1;
      @(negedge clk);
      n_total++; if (ctl !== 7'b0000000) $display("FAIL b2b_release: got %b want %b", ctl, 7'b0000000); else n_pass++;
      next_cycle();
      drive_idle();
      @(negedge clk);
      es = 16'(PERF ? exp_stall : 0);
      n_total++; if (bus_if.stall_count !== es) $display("FAIL b2b_stall_count: got %0d want %0d", bus_if.stall_count, es); else n_pass++;
      next_cycle();
   endtask

   task automatic test_timeout();
      logic [15:0] es;
      logic [6:0]  exp;
      bus_if.mem_req = 1'b1; bus_if.mem_ready = 1'b0;
      for (int c = 0; c < 16; c++) begin
         exp = (c == 0) ? 7'b1110000 : 7'b1110010;
         @(negedge clk);
         n_total++; if (ctl !== exp) $display("FAIL to_wait_c%0d: got %b want %b", c, ctl, exp); else n_pass++;
         exp_stall++;
         next_cycle();
         bus_if.mem_req = 1'b0;
      end
      @(negedge clk);
      n_total++; if (ctl !== 7'b0000001) $display("FAIL to_abort: got %b want %b", ctl, 7'b0000001); else n_pass++;
      es = 16'(PERF ? exp_stall : 0);
      n_total++; if (bus_if.stall_count !== es) $display("FAIL to_stall_count: got %0d want %0d", bus_if.stall_count, es); else n_pass++;
      next_cycle();
      @(negedge clk);
      n_total++; if (ctl !== 7'b0000000) $display("FAIL to_err_one_cycle: got %b want %b", ctl, 7'b0000000); else n_pass++;
      next_cycle();
   endtask

   task automatic test_ready_at_timeout();
      // Completion in the timeout cycle counts as success: no mem_err.
      bus_if.mem_req = 1'b1; bus_if.mem_ready = 1'b0;
      for (int c = 0; c < 15; c++) begin
         exp_stall++;
         next_cycle();
         bus_if.mem_req = 1'b0;
      end
      bus_if.mem_ready = 1'b1;
      @(negedge clk);
      n_total++; if (ctl !== 7'b0000000) $display("FAIL rt_release: got %b want %b", ctl, 7'b0000000); else n_pass++;
      next_cycle();
      drive_idle();
      @(negedge clk);
      n_total++; if (ctl !== 7'b0000000) $display("FAIL rt_no_err: got %b want %b", ctl, 7'b0000000); else n_pass++;
      next_cycle();
   endtask

   task automatic test_frozen_branch();
      logic [15:0] ef;
      bus_if.mem_req = 1'b1; bus_if.mem_ready = 1'b0; bus_if.ex_branch_taken = 1'b1;
      @(negedge clk);
      n_total++; if (ctl !== 7'b1110000) $display("FAIL fb_req: got %b want %b", ctl, 7'b1110000); else n_pass++;
      exp_stall++;
      next_cycle();
      @(negedge clk);
      n_total++; if (ctl !== 7'b1110010) $display("FAIL fb_wait: got %b want %b", ctl, 7'b1110010); else n_pass++;
      exp_stall++;
      next_cycle();
      bus_if.mem_ready = 1'b1;
      @(negedge clk);
      n_total++; if (ctl !== 7'b0000000) $display("FAIL fb_release: got %b want %b", ctl, 7'b0000000); else n_pass++;
      next_cycle();
      bus_if.mem_req = 1'b0; bus_if.mem_ready = 1'b0;
      @(negedge clk);
      n_total++; if (ctl !== 7'b0001100) $display("FAIL fb_flush_after: got %b want %b", ctl, 7'b0001100); else n_pass++;
      exp_flush++;
      next_cycle();
      drive_idle();
      @(negedge clk);
      ef = 16'(PERF ? exp_flush : 0);
      n_total++; if (bus_if.flush_count !== ef) $display("FAIL fb_flush_count: got %0d want %0d", bus_if.flush_count, ef); else n_pass++;
      next_cycle();
   endtask

   task automatic test_reset_mid_wait();
      bus_if.mem_req = 1'b1; bus_if.mem_ready = 1'b0;
      next_cycle();
      @(negedge clk);
      n_total++; if (ctl !== 7'b1110010) $display("FAIL rm_in_wait: got %b want %b", ctl, 7'b1110010); else n_pass++;
      #1;
      rst = 1'b1;
      #1;
      n_total++; if (ctl !== 7'b0000000) $display("FAIL rm_async_drop: got %b want %b", ctl, 7'b0000000); else n_pass++;
      n_total++; if (bus_if.stall_count !== 16'd0) $display("FAIL rm_stall_count: got %0d want 0", bus_if.stall_count); else n_pass++;
      exp_stall = 0;
      exp_flush = 0;
      next_cycle();
      drive_idle();
      rst = 1'b0;
      @(negedge clk);
      n_total++; if (ctl !== 7'b0000000) $display("FAIL rm_after: got %b want %b", ctl, 7'b0000000); else n_pass++;
      next_cycle();
      // The state is RUN again: a branch flushes immediately.
      bus_if.ex_branch_taken = 1'b1;
      @(negedge clk);
      n_total++; if (ctl !== 7'b0001100) $display("FAIL rm_run_state: got %b want %b", ctl, 7'b0001100); else n_pass++;
      next_cycle();
      drive_idle();
   endtask

   initial begin
      n_pass    = 0;
      n_total   = 0;
      exp_stall = 0;
      exp_flush = 0;
      rst       = 1'b1;
      drive_idle();
      test_reset();
      test_branch_vs_load_use();
      test_load_use();
      test_mem_wait();
      test_timeout();
      test_ready_at_timeout();
      test_frozen_branch();
      test_reset_mid_wait();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   initial begin
      #20000;
      $display("FAIL watchdog: got timeout want completion");
      $fatal(1, "watchdog expired");
   end
endmodule
